fifo_word_serializer: RTL
=========================

// Module: fifo_word_serializer
// PURPOSE
//  Read side of the 8-deep operand FIFO. Pops one Data-bit operand word when the FIFO is non-empty
//  and streams it LSB-chunk-first as Data/Chunk words of Chunk bits over a valid/ready handshake.
//  Sits between the operand FIFO output (Data_out / Out_Busy / rd_en) and the digit-serial
//  multiplier datapath.
// PARAMETERS
//  Data   512  operand word width; must equal the FIFO Data parameter
//  Chunk  64   output chunk width; Data % Chunk == 0 is required
//  Cnt_w  3    chunk counter width; 2**Cnt_w >= Data/Chunk
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  fifo_data    in   Data   FIFO Data_out; registered, valid the cycle after fifo_rd_en
//  fifo_empty   in   1      FIFO Out_Busy; 1 = empty
//  fifo_rd_en   out  1      FIFO pop strobe, one cycle per word
//  chunk_out    out  Chunk  current chunk; chunk 0 = fifo_data[Chunk-1:0]
//  chunk_valid  out  1      chunk_out holds a valid chunk
//  chunk_ready  in   1      consumer accepts chunk_out when valid && ready
//  chunk_last   out  1      qualifies the final chunk (index Data/Chunk-1) of a word
//  busy         out  1      high in LOAD or SEND
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): state=IDLE; shift reg, count, chunk_out = 0.
//    chunk_valid, chunk_last, busy = 0. fifo_rd_en = 0 whenever rst=1, regardless of fifo_empty.
//  - FSM states: IDLE, LOAD, SEND.
//    IDLE: fifo_rd_en = !fifo_empty (combinational). If !fifo_empty, go to LOAD; else stay in IDLE.
//    LOAD: fifo_rd_en = 0. Capture fifo_data into shift reg; count = 0; go to SEND.
//    SEND: chunk_valid = 1; chunk_out = sreg[Chunk-1:0]; chunk_last = (count == Data/Chunk-1).
//      On valid && ready: sreg >>= Chunk (zero fill), count++. If chunk_last, go to IDLE.
//      On valid && !ready: chunk_out, chunk_last, sreg, count hold exactly.
//  - Latency: with fifo_rd_en high in cycle t, LOAD is cycle t+1 and the first chunk_valid is
//    cycle t+2. With ready held high, a word takes Data/Chunk + 2 cycles.
//  - The last chunk is accepted in cycle s; IDLE is s+1, with fifo_rd_en high if non-empty.
//    The next word's first chunk is in s+3. No prefetch: at most one popped word is in flight.
//  - Exactly one fifo_rd_en pulse per word. fifo_rd_en is never asserted while fifo_empty=1, so
//    the FIFO underflow guard is never exercised.
//  - Reset mid-operation: if rst arrives in LOAD or SEND, the word in flight is discarded.
//    A word already popped is lost and is not re-read. chunk_valid is 0 the next cycle.
//  - Outputs other than fifo_rd_en are registered or decoded from state and sreg only.
//    There is no combinational path from chunk_ready to chunk_valid or chunk_out.
// TESTING
//  1 rst=1 for 3 cycles, fifo_empty=0 -> fifo_rd_en=0, chunk_valid=0, busy=0 throughout.
//  2 Single word, chunk i = 64'h(i+1), ready=1 -> one fifo_rd_en pulse. chunk_valid from t+2 for
//    8 consecutive cycles with values 1..8. chunk_last only on value 8. busy=1 for 9 cycles.
//  3 Same word, ready toggled 1,0,0,1,... -> chunk_out stable while stalled. Values 1..8, no
//    skips or duplicates. chunk_last stays with value 8 until accepted.
//  4 Two words queued (A, B), ready=1 -> exactly 2 rd_en pulses. B's first chunk 3 cycles after
//    A's last. Output order A0..A7, B0..B7.
//  5 rst pulsed after 3 chunks of A accepted, B queued -> chunk_valid=0 the next cycle. Restart
//    pops B and emits B0..B7. A3..A7 are never seen.
//  6 fifo_empty=1 for 50 cycles -> fifo_rd_en never high. State stays IDLE. Then word C is
//    pushed -> fifo_rd_en the first cycle fifo_empty=0, C0 at +2.

Source files
------------

// File: rtl/fifo_word_serializer.sv
// fifo_word_serializer
//   Read side of the 8-deep operand FIFO. When the FIFO is non-empty it pops one
//   Data-bit operand word. It then streams that word to the digit-serial
//   multiplier datapath as Data/Chunk chunks of Chunk bits, least-significant
//   chunk first, over a valid/ready handshake.
//
// Ports
//   clk          in   1      single clock, rising edge
//   rst          in   1      synchronous, active-high reset
//   fifo_data    in   Data   FIFO Data_out, valid the cycle after fifo_rd_en
//   fifo_empty   in   1      FIFO Out_Busy, 1 = empty
//   fifo_rd_en   out  1      FIFO pop strobe, one cycle per word
//   chunk_out    out  Chunk  current chunk (chunk 0 = fifo_data[Chunk-1:0])
//   chunk_valid  out  1      chunk_out holds a valid chunk
//   chunk_ready  in   1      consumer accepts chunk_out when valid && ready
//   chunk_last   out  1      qualifies the final chunk of a word
//   busy         out  1      high while a word is being loaded or sent
module fifo_word_serializer #(
  parameter int unsigned Data  = 512,
  parameter int unsigned Chunk = 64,
  parameter int unsigned Cnt_w = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Data-1:0]  fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic [Chunk-1:0] chunk_out,
  output logic             chunk_valid,
  input  logic             chunk_ready,
  output logic             chunk_last,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  localparam int unsigned        NChunk  = Data / Chunk;
  localparam logic [Cnt_w-1:0]   LastIdx = Cnt_w'(NChunk - 1);

  logic [1:0]       state_q, state_d;
  logic [Data-1:0]  sreg_q,  sreg_d;
  logic [Cnt_w-1:0] cnt_q,   cnt_d;

  logic is_last;
  assign is_last = (cnt_q == LastIdx);

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) state_d = S_LOAD;
      end
      S_LOAD: begin
        // The FIFO output is registered, so the popped word is only
        // present one cycle after the pop strobe.
        sreg_d  = fifo_data;
        cnt_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (chunk_ready) begin
          sreg_d = sreg_q >> Chunk;
          cnt_d  = cnt_q + Cnt_w'(1);
          if (is_last) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // The pop is the only combinational output. It is gated by rst so that a
  // word is never popped into a register that is being cleared.
  assign fifo_rd_en  = !rst && (state_q == S_IDLE) && !fifo_empty;
  assign chunk_valid = (state_q == S_SEND);
  assign chunk_out   = sreg_q[Chunk-1:0];
  assign chunk_last  = (state_q == S_SEND) && is_last;
  assign busy        = (state_q != S_IDLE);

endmodule
